chan_ptr_sequencer: RTL and testbench
=====================================

// Module: chan_ptr_sequencer
// PURPOSE
//  Services transfer requests from 16 I/O channels using the channel register file. Each channel keeps
//  its transfer address in pointer reg P2 and its remaining count in P3. Requests are arbitrated
//  round-robin. The block reads P2/P3, presents the address to the datapath, then writes back
//  P2+1 and P3-1. It is the only sequencer driving the register-file channel/select/write ports.
// PARAMETERS
//  NCHAN     16   number of channels (chan id width CW = 4)
//  DW        12   pointer register width
//  ADDR_SEL  2    pointer select holding address
//  CNT_SEL   3    pointer select holding remaining count
// PORTS
//  clk        in   1    clock, all state updates on posedge
//  rst_n      in   1    asynchronous active-low reset
//  hold       in   1    host is programming regfile; no new grant while high
//  req        in   16   per-channel transfer request (level, held until done)
//  xfer_valid out  1    xfer_chan/xfer_addr valid, awaiting ack
//  xfer_chan  out  4    channel being serviced
//  xfer_addr  out  12   address for this transfer (old P2)
//  xfer_ack   in   1    datapath accepted transfer
//  done       out  16   one-cycle pulse to serviced channel after write-back
//  tc         out  1    one-cycle pulse with done when new count == 0
//  err_zero   out  1    one-cycle pulse: granted channel had count 0, no transfer
//  busy       out  1    FSM not in IDLE
//  rchanid    out  4    regfile read channel
//  psel0      out  2    regfile read port 0 select (fixed ADDR_SEL)
//  psel1      out  2    regfile read port 1 select (fixed CNT_SEL)
//  qp0, qp1   in   12   regfile read data, valid one clock after rchanid/psel applied
//  wchanid    out  4    regfile write channel
//  pselw      out  2    regfile write select
//  d12        out  12   regfile write data
//  wep        out  1    regfile write enable; write commits on the posedge where wep=1
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, last=15 (so ch0 has top priority), all outputs 0,
//   psel0=ADDR_SEL, psel1=CNT_SEL. Deassertion takes effect at the next posedge only.
//  Arbitration: in IDLE with hold=0 and req!=0, the grant goes to the first set req scanning
//   last+1, last+2, ... with wrap 15->0. last updates on grant. req sampled only in IDLE.
//  FSM (one state per clock unless noted):
//   IDLE  : rchanid<=winner, chan latched -> READ. hold=1 or req=0 -> stay.
//   READ  : wait for regfile read latency -> EVAL.
//   EVAL  : latch addr=qp0, cnt=qp1. If cnt==0: err_zero=1 -> IDLE (no writes, no done).
//           else xfer_valid=1 -> XFER.
//   XFER  : hold xfer_valid/chan/addr stable until xfer_ack=1; on ack clear valid -> WADDR.
//           ack in the same cycle valid first rises is legal (min 1 cycle in XFER).
//   WADDR : wchanid=chan, pselw=ADDR_SEL, d12=addr+1 (mod 2^12, FFF->000), wep=1 -> WCNT.
//   WCNT  : pselw=CNT_SEL, d12=cnt-1, wep=1; done[chan]=1; tc=1 if cnt-1==0 -> IDLE.
//  Minimum service time 5 clocks plus ack wait. wep is 0 in every other state.
//  hold rising mid-service does not abort; the sequence completes, then the FSM stays IDLE.
//  xfer_ack outside XFER is ignored. Reset mid-sequence: writes not yet issued are lost.
//  Counting arithmetic is unsigned DW-bit. No write is issued for a zero-count channel.
// TESTING
//  1 reset: rst_n=0 mid-XFER -> all outputs 0 immediately, busy=0; after release ch0 wins first.
//  2 single: C5 P2=0x100,P3=0x003, req[5]=1, ack after 2 cycles -> xfer_addr=0x100; then
//    P2=0x101, P3=0x002, done[5] pulse, tc=0.
//  3 wrap/tc: C9 P2=0xFFF,P3=0x001 -> addr 0xFFF; write-back P2=0x000,P3=0x000; tc=1 with done[9].
//  4 round-robin: req=0x8003 held, all counts 5 -> grant order 0,1,15,0,1,15; no starvation.
//  5 zero count: C2 P3=0 -> err_zero pulse, xfer_valid never 1, P2/P3 unchanged, done=0.
//  6 hold: hold=1 with req[4]=1 -> no grant for 20 cycles; hold=0 -> C4 serviced; check no wep
//    pulse while hold=1 and FSM idle; other channels' P2/P3 stay unchanged throughout.

Source files
------------

// File: rtl/chan_ptr_sequencer.sv
// chan_ptr_sequencer: round-robin sequencer that reads a channel's address/count pointers, hands the
// address to the datapath, then writes back address+1 and count-1 through the channel register file.
module chan_ptr_sequencer #(
  parameter int NCHAN = 16,
  parameter int DW = 12,
  parameter logic [1:0] ADDR_SEL = 2'd2,
  parameter logic [1:0] CNT_SEL = 2'd3,
  localparam int CW = $clog2(NCHAN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold,
  input  logic [NCHAN-1:0] req,
  output logic             xfer_valid,
  output logic [CW-1:0]    xfer_chan,
  output logic [DW-1:0]    xfer_addr,
  input  logic             xfer_ack,
  output logic [NCHAN-1:0] done,
  output logic             tc,
  output logic             err_zero,
  output logic             busy,
  output logic [CW-1:0]    rchanid,
  output logic [1:0]       psel0,
  output logic [1:0]       psel1,
  input  logic [DW-1:0]    qp0,
  input  logic [DW-1:0]    qp1,
  output logic [CW-1:0]    wchanid,
  output logic [1:0]       pselw,
  output logic [DW-1:0]    d12,
  output logic             wep
);
  typedef enum logic [2:0] {IDLE, READ, EVAL, XFER, WADDR, WCNT} state_t;
  state_t state, nxt;
  logic [CW-1:0] last, chan, winner, idx;
  logic [DW-1:0] addr, cnt;
  logic found, grant;
  // Overwrite from the far end so the nearest requester after last wins.
  always_comb begin
    winner = last;
    found = 1'b0;
    idx = '0;
    for (int i = NCHAN; i >= 1; i--) begin
      idx = last + CW'(i);
      if (req[idx]) begin
        winner = idx;
        found = 1'b1;
      end
    end
  end
  assign grant = state == IDLE && !hold && found;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      last <= '1;
      chan <= '0;
      rchanid <= '0;
      addr <= '0;
      cnt <= '0;
    end else begin
      if (grant) begin
        last <= winner;
        chan <= winner;
        rchanid <= winner;
      end
      if (state == EVAL) begin
        addr <= qp0;
        cnt <= qp1;
      end
    end
  always_comb begin
    nxt = state;
    xfer_valid = 1'b0;
    err_zero = 1'b0;
    wep = 1'b0;
    wchanid = '0;
    pselw = '0;
    d12 = '0;
    done = '0;
    tc = 1'b0;
    unique case (state)
      IDLE: nxt = grant ? READ : IDLE;
      READ: nxt = EVAL;
      EVAL: begin
        err_zero = qp1 == '0;
        nxt = err_zero ? IDLE : XFER;
      end
      XFER: begin
        xfer_valid = 1'b1;
        nxt = xfer_ack ? WADDR : XFER;
      end
      WADDR: begin
        wep = 1'b1;
        wchanid = chan;
        pselw = ADDR_SEL;
        d12 = addr + DW'(1);
        nxt = WCNT;
      end
      WCNT: begin
        wep = 1'b1;
        wchanid = chan;
        pselw = CNT_SEL;
        d12 = cnt - DW'(1);
        done[chan] = 1'b1;
        tc = d12 == '0;
        nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end
  assign busy = state != IDLE;
  assign xfer_chan = chan;
  assign xfer_addr = addr;
  assign psel0 = ADDR_SEL;
  assign psel1 = CNT_SEL;
endmodule

// File: tb/tb_chan_ptr_sequencer.sv
// tb_chan_ptr_sequencer: directed bench with a registered-read register file model around the sequencer.
module tb_chan_ptr_sequencer;
  logic clk = 0, rst_n = 0, hold = 0, xfer_ack = 0;
  logic [15:0] req = '0;
  logic xfer_valid, tc, err_zero, busy, wep;
  logic [3:0] xfer_chan, rchanid, wchanid;
  logic [11:0] xfer_addr, d12;
  logic [11:0] qp0 = '0, qp1 = '0;
  logic [15:0] done;
  logic [1:0] psel0, psel1, pselw;
  logic [11:0] rf [16][4];
  logic pl_en = 0;
  logic [3:0] pl_ch = '0;
  logic [11:0] pl_p2 = '0, pl_p3 = '0;
  int n_checks = 0, n_fail = 0;

  chan_ptr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .req(req),
    .xfer_valid(xfer_valid), .xfer_chan(xfer_chan), .xfer_addr(xfer_addr), .xfer_ack(xfer_ack),
    .done(done), .tc(tc), .err_zero(err_zero), .busy(busy),
    .rchanid(rchanid), .psel0(psel0), .psel1(psel1), .qp0(qp0), .qp1(qp1),
    .wchanid(wchanid), .pselw(pselw), .d12(d12), .wep(wep)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    qp0 <= rf[rchanid][psel0];
    qp1 <= rf[rchanid][psel1];
    if (wep) rf[wchanid][pselw] <= d12;
    if (pl_en) begin
      rf[pl_ch][2] <= pl_p2;
      rf[pl_ch][3] <= pl_p3;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [3:0] ch, input logic [11:0] p2, input logic [11:0] p3);
    pl_ch = ch;
    pl_p2 = p2;
    pl_p3 = p3;
    pl_en = 1;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (!xfer_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, " valid"}, 32'(xfer_valid), 1);
  endtask

  task automatic do_xfer(input string tag, input logic [3:0] ch, input logic [11:0] addr,
                         input logic [11:0] newcnt, input logic tc_exp, input int dly,
                         input logic [15:0] req_after);
    logic [11:0] a1;
    a1 = addr + 12'd1;
    wait_valid(tag);
    check({tag, " chan"}, 32'(xfer_chan), 32'(ch));
    check({tag, " addr"}, 32'(xfer_addr), 32'(addr));
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      check({tag, " valid held"}, 32'(xfer_valid), 1);
      check({tag, " no wep in xfer"}, 32'(wep), 0);
    end
    xfer_ack = 1;
    @(negedge clk);
    xfer_ack = 0;
    check({tag, " waddr wep"}, 32'(wep), 1);
    check({tag, " waddr valid"}, 32'(xfer_valid), 0);
    check({tag, " waddr wchan"}, 32'(wchanid), 32'(ch));
    check({tag, " waddr psel"}, 32'(pselw), 2);
    check({tag, " waddr data"}, 32'(d12), 32'(a1));
    check({tag, " waddr done"}, 32'(done), 0);
    @(negedge clk);
    check({tag, " wcnt wep"}, 32'(wep), 1);
    check({tag, " wcnt psel"}, 32'(pselw), 3);
    check({tag, " wcnt data"}, 32'(d12), 32'(newcnt));
    check({tag, " done"}, 32'(done), 32'(16'd1 << ch));
    check({tag, " tc"}, 32'(tc), 32'(tc_exp));
    req = req_after;
    @(negedge clk);
    check({tag, " done pulse"}, 32'(done), 0);
    check({tag, " tc pulse"}, 32'(tc), 0);
    check({tag, " wep idle"}, 32'(wep), 0);
  endtask

  initial begin
    logic [3:0] rr_ch [6] = '{4'd0, 4'd1, 4'd15, 4'd0, 4'd1, 4'd15};
    logic [11:0] rr_addr [6] = '{12'h200, 12'h300, 12'h7F0, 12'h201, 12'h301, 12'h7F1};
    logic [11:0] rr_cnt [6] = '{12'd4, 12'd4, 12'd4, 12'd3, 12'd3, 12'd3};
    logic seen, bad;
    int n;
    for (int c = 0; c < 16; c++)
      for (int s = 0; s < 4; s++) rf[c][s] = '0;
    @(negedge clk);
    preload(5, 12'h100, 12'h003);
    preload(9, 12'hFFF, 12'h001);
    preload(0, 12'h200, 12'd5);
    preload(1, 12'h300, 12'd5);
    preload(15, 12'h7F0, 12'd5);
    preload(2, 12'h222, 12'h000);
    preload(4, 12'h444, 12'h007);
    preload(7, 12'h777, 12'h077);
    check("rst valid", 32'(xfer_valid), 0);
    check("rst busy", 32'(busy), 0);
    check("rst wep", 32'(wep), 0);
    check("rst done", 32'(done), 0);
    check("rst rchanid", 32'(rchanid), 0);
    check("rst psel0", 32'(psel0), 2);
    check("rst psel1", 32'(psel1), 3);
    rst_n = 1;
    @(negedge clk);
    check("idle busy", 32'(busy), 0);

    req = 16'h0020;
    do_xfer("single", 5, 12'h100, 12'h002, 0, 2, 16'h0000);
    check("single p2", 32'(rf[5][2]), 12'h101);
    check("single p3", 32'(rf[5][3]), 12'h002);

    req = 16'h0200;
    do_xfer("wrap", 9, 12'hFFF, 12'h000, 1, 0, 16'h0000);
    check("wrap p2", 32'(rf[9][2]), 12'h000);
    check("wrap p3", 32'(rf[9][3]), 12'h000);

    req = 16'h8003;
    wait_valid("rstmid");
    check("rstmid chan", 32'(xfer_chan), 15);
    #2 rst_n = 0;
    #1;
    check("rstmid valid", 32'(xfer_valid), 0);
    check("rstmid busy", 32'(busy), 0);
    check("rstmid chan0", 32'(xfer_chan), 0);
    check("rstmid addr0", 32'(xfer_addr), 0);
    check("rstmid rchanid", 32'(rchanid), 0);
    @(negedge clk);
    rst_n = 1;
    check("rstmid p2 kept", 32'(rf[15][2]), 12'h7F0);
    check("rstmid p3 kept", 32'(rf[15][3]), 12'd5);

    for (int k = 0; k < 6; k++)
      do_xfer($sformatf("rr%0d", k), rr_ch[k], rr_addr[k], rr_cnt[k], 0, k % 3,
              k == 5 ? 16'h0000 : 16'h8003);
    check("rr p2 c0", 32'(rf[0][2]), 12'h202);
    check("rr p2 c1", 32'(rf[1][2]), 12'h302);
    check("rr p2 c15", 32'(rf[15][2]), 12'h7F2);
    check("rr p3 c15", 32'(rf[15][3]), 12'd3);

    req = 16'h0004;
    seen = 0;
    n = 0;
    while (!err_zero && n < 20) begin
      @(negedge clk);
      seen |= xfer_valid;
      n++;
    end
    check("zero err", 32'(err_zero), 1);
    check("zero done", 32'(done), 0);
    check("zero wep", 32'(wep), 0);
    req = '0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen |= xfer_valid;
    end
    check("zero err pulse", 32'(err_zero), 0);
    check("zero valid never", 32'(seen), 0);
    check("zero p2", 32'(rf[2][2]), 12'h222);
    check("zero p3", 32'(rf[2][3]), 12'h000);

    hold = 1;
    req = 16'h0010;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      bad |= busy | wep | xfer_valid;
    end
    check("hold no grant", 32'(bad), 0);
    hold = 0;
    do_xfer("hold", 4, 12'h444, 12'h006, 0, 1, 16'h0000);
    check("hold p2", 32'(rf[4][2]), 12'h445);
    check("other c5 p2", 32'(rf[5][2]), 12'h101);
    check("other c9 p3", 32'(rf[9][3]), 12'h000);
    check("other c7 p2", 32'(rf[7][2]), 12'h777);
    check("other c7 p3", 32'(rf[7][3]), 12'h077);
    check("other c2 p3", 32'(rf[2][3]), 12'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
